// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
//
// Signed two's-complement sequential divider. It uses restoring division and
// produces one quotient bit per clock. Signs are stripped when an operation
// starts and are applied again when the result is published. The quotient
// truncates toward zero, and the remainder takes the sign of the dividend.
//
// Ports
//   clk        sole clock, rising-edge
//   reset      asynchronous, active-low reset
//   DivCtrl    start request, honoured only while idle
//   dividendo  signed dividend, captured at start
//   divisor    signed divisor, captured at start
//   HI         remainder result register
//   LO         quotient result register
//   busy       high while iterating or publishing
//   done       one-cycle pulse when a result or a divide-by-zero is reported
//   DivZero    sticky divide-by-zero flag, cleared by the next accepted start
//
// Timing: start accepted at edge 0 -> HI/LO/done update at edge WIDTH+1.
// A zero divisor reports at edge 1 and leaves HI/LO untouched.
// -----------------------------------------------------------------------------
module divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             DivCtrl,
    input  logic [WIDTH-1:0] dividendo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2,
        ZERO   = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] quo_reg;      // dividend magnitude, shifted into quotient
    logic [WIDTH-1:0] dvs_reg;      // divisor magnitude
    logic [WIDTH-1:0] rem_reg;      // partial remainder
    logic [CW-1:0]    count_reg;
    logic             sign_dvd_reg;
    logic             sign_dvs_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             done_reg;
    logic             divzero_reg;

    // Magnitudes of the live inputs. Negating the most negative value returns
    // the same bit pattern, which read as unsigned is exactly 2^(WIDTH-1).
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    assign dvd_mag = dividendo[WIDTH-1] ? ('0 - dividendo) : dividendo;
    assign dvs_mag = divisor[WIDTH-1]   ? ('0 - divisor)   : divisor;

    // One restoring step. The remainder is always below the divisor magnitude,
    // so the shifted remainder fits in WIDTH bits. The subtraction is done in
    // WIDTH+1 bits so that its borrow is a clean "does not fit" indicator.
    logic [WIDTH-1:0] rem_shift;
    logic [WIDTH:0]   diff;
    logic             fits;
    assign rem_shift = {rem_reg[WIDTH-2:0], quo_reg[WIDTH-1]};
    assign diff      = {1'b0, rem_shift} - {1'b0, dvs_reg};
    assign fits      = ~diff[WIDTH];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (DivCtrl) begin
                    state_next = (divisor == '0) ? ZERO : CALC;
                end
            end
            CALC: begin
                if (count_reg == LAST_STEP) begin
                    state_next = FINISH;
                end
            end
            FINISH:  state_next = IDLE;
            ZERO:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quo_reg      <= '0;
            dvs_reg      <= '0;
            rem_reg      <= '0;
            count_reg    <= '0;
            sign_dvd_reg <= 1'b0;
            sign_dvs_reg <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
            divzero_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (DivCtrl) begin
                        quo_reg      <= dvd_mag;
                        dvs_reg      <= dvs_mag;
                        rem_reg      <= '0;
                        count_reg    <= '0;
                        sign_dvd_reg <= dividendo[WIDTH-1];
                        sign_dvs_reg <= divisor[WIDTH-1];
                        divzero_reg  <= 1'b0;
                    end
                end
                CALC: begin
                    quo_reg   <= {quo_reg[WIDTH-2:0], fits};
                    rem_reg   <= fits ? diff[WIDTH-1:0] : rem_shift;
                    count_reg <= count_reg + CW'(1);
                end
                FINISH: begin
                    lo_reg   <= (sign_dvd_reg ^ sign_dvs_reg) ? ('0 - quo_reg) : quo_reg;
                    hi_reg   <= sign_dvd_reg ? ('0 - rem_reg) : rem_reg;
                    done_reg <= 1'b1;
                end
                ZERO: begin
                    divzero_reg <= 1'b1;
                    done_reg    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign HI      = hi_reg;
    assign LO      = lo_reg;
    assign busy    = (state_reg == CALC) || (state_reg == FINISH);
    assign done    = done_reg;
    assign DivZero = divzero_reg;

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider
//
// Directed and randomized checks of the 32-bit divider. Inputs are driven 1 ns
// after a rising edge, and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_divider;

    logic        clk;
    logic        reset;
    logic        DivCtrl;
    logic [31:0] dividendo;
    logic [31:0] divisor;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        done;
    logic        DivZero;

    int total = 0;
    int bad   = 0;

    divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .DivCtrl   (DivCtrl),
        .dividendo (dividendo),
        .divisor   (divisor),
        .HI        (HI),
        .LO        (LO),
        .busy      (busy),
        .done      (done),
        .DivZero   (DivZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue a one-cycle start, then wait (bounded) for done. lat is the number
    // of edges after the start edge at which done was first seen high.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
        dividendo = a;
        divisor   = b;
        DivCtrl   = 1'b1;
        tick();
        DivCtrl = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        $display("op %h / %h -> LO=%h HI=%h DivZero=%0d lat=%0d", a, b, LO, HI, DivZero, lat);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0000_0000;
            1: v = 32'h0000_0001;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'h7FFF_FFFF;
            5: v = 32'($urandom_range(0, 40)) - 32'd20;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int lat;
        int seen;
        logic [31:0] exp_lo, exp_hi;
        longint sa, sb, q, r;

        reset     = 1'b0;
        DivCtrl   = 1'b0;
        dividendo = '0;
        divisor   = '0;

        // ---- reset state ----
        #2;
        chk("rst_HI", HI, 32'd0);
        chk("rst_LO", LO, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_DivZero", 32'(DivZero), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // ---- 100 / 7 with cycle-exact busy/done ----
        dividendo = 32'd100;
        divisor   = 32'd7;
        DivCtrl   = 1'b1;
        tick();                                   // edge 0
        DivCtrl = 1'b0;
        chk("p_busy_e0", 32'(busy), 32'd1);
        for (int i = 1; i <= 32; i++) begin
            tick();
            chk($sformatf("p_busy_done_e%0d", i), 32'({busy, done}), 32'b10);
        end
        tick();                                   // edge 33
        $display("op 100 / 7 -> LO=%h HI=%h done=%0d busy=%0d", LO, HI, done, busy);
        chk("p_done", 32'(done), 32'd1);
        chk("p_busy_off", 32'(busy), 32'd0);
        chk("p_LO", LO, 32'd14);
        chk("p_HI", HI, 32'd2);
        chk("p_DivZero", 32'(DivZero), 32'd0);
        tick();
        chk("p_done_pulse", 32'(done), 32'd0);
        chk("p_LO_hold", LO, 32'd14);

        // ---- mixed signs ----
        run_op(32'hFFFF_FFF9, 32'd2, lat);        // -7 / 2
        chk("m1_lat", 32'(lat), 32'd33);
        chk("m1_LO", LO, 32'hFFFF_FFFD);
        chk("m1_HI", HI, 32'hFFFF_FFFF);
        run_op(32'd7, 32'hFFFF_FFFE, lat);        // 7 / -2
        chk("m2_LO", LO, 32'hFFFF_FFFD);
        chk("m2_HI", HI, 32'd1);
        run_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, lat); // -7 / -2
        chk("m3_LO", LO, 32'd3);
        chk("m3_HI", HI, 32'hFFFF_FFFF);

        // ---- divide by zero ----
        run_op(32'd100, 32'd7, lat);
        run_op(32'd5, 32'd0, lat);
        chk("z_lat", 32'(lat), 32'd1);
        chk("z_done", 32'(done), 32'd1);
        chk("z_DivZero", 32'(DivZero), 32'd1);
        chk("z_LO", LO, 32'd14);
        chk("z_HI", HI, 32'd2);
        tick();
        chk("z_done_pulse", 32'(done), 32'd0);
        chk("z_sticky", 32'(DivZero), 32'd1);
        dividendo = 32'd9;
        divisor   = 32'd3;
        DivCtrl   = 1'b1;
        tick();
        DivCtrl = 1'b0;
        chk("z_clear", 32'(DivZero), 32'd0);
        seen = 0;
        while (!done && seen < 40) begin
            tick();
            seen++;
        end
        chk("z_next_LO", LO, 32'd3);

        // ---- overflow ----
        run_op(32'h8000_0000, 32'hFFFF_FFFF, lat);
        chk("ov_LO", LO, 32'h8000_0000);
        chk("ov_HI", HI, 32'd0);
        chk("ov_DivZero", 32'(DivZero), 32'd0);

        // ---- DivCtrl ignored while busy ----
        dividendo = 32'd100;
        divisor   = 32'd7;
        DivCtrl   = 1'b1;
        tick();
        DivCtrl = 1'b0;
        repeat (9) tick();
        dividendo = 32'd50;
        divisor   = 32'd5;
        DivCtrl   = 1'b1;
        repeat (3) tick();
        DivCtrl = 1'b0;
        lat = 12;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        $display("op 100 / 7 with late start -> LO=%h HI=%h lat=%0d", LO, HI, lat);
        chk("ig_lat", 32'(lat), 32'd33);
        chk("ig_LO", LO, 32'd14);
        chk("ig_HI", HI, 32'd2);

        // ---- reset in the middle of CALC ----
        tick();
        dividendo = 32'd100;
        divisor   = 32'd7;
        DivCtrl   = 1'b1;
        tick();
        DivCtrl = 1'b0;
        repeat (15) tick();
        reset = 1'b0;
        #1;
        chk("ar_HI", HI, 32'd0);
        chk("ar_LO", LO, 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_done", 32'(done), 32'd0);
        chk("ar_DivZero", 32'(DivZero), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || HI != 0 || LO != 0) seen++;
        end
        chk("ar_no_done", 32'(seen), 32'd0);
        run_op(32'd100, 32'd7, lat);
        chk("ar_restart_lat", 32'(lat), 32'd33);
        chk("ar_restart_LO", LO, 32'd14);
        chk("ar_restart_HI", HI, 32'd2);

        // ---- randomized back-to-back against a reference model ----
        exp_lo = LO;
        exp_hi = HI;
        for (int n = 0; n < 1000; n++) begin
            logic [31:0] a, b;
            a = pick();
            b = pick();
            run_op(a, b, lat);
            if (b == 0) begin
                chk("r_lat", 32'(lat), 32'd1);
                chk("r_DivZero", 32'(DivZero), 32'd1);
            end else begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q  = sa / sb;
                r  = sa % sb;
                exp_lo = q[31:0];
                exp_hi = r[31:0];
                chk("r_lat", 32'(lat), 32'd33);
                chk("r_DivZero", 32'(DivZero), 32'd0);
            end
            chk("r_LO", LO, exp_lo);
            chk("r_HI", HI, exp_hi);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
